// File: rtl/mfp_ahb_intc_if.sv
// AHB-Lite slave port bundle for the interrupt controller.
interface mfp_ahb_intc_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [4:0]  HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (output HSEL, HTRANS, HWRITE, HADDR, HWDATA,
                  input  HRDATA, HREADY, HRESP);
  modport slave  (input  HSEL, HTRANS, HWRITE, HADDR, HWDATA,
                  output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/mfp_ahb_intc.sv
// N_SRC-input interrupt controller: synchronise, edge/level detect, latch,
// mask and priority-encode onto one core interrupt plus a source vector.
module mfp_ahb_intc #(
  parameter int N_SRC       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             SI_Reset,
  mfp_ahb_intc_if.slave    bus,
  input  logic [N_SRC-1:0] IRQ_SRC,
  output logic             irq,
  output logic [5:0]       irq_vec
);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_r;
  logic [N_SRC-1:0] prev_r, pending_r, enable_r, mode_r, polarity_r;
  logic             dp_valid_r, dp_write_r;
  logic [2:0]       dp_addr_r;
  logic             irq_r;
  logic [5:0]       irq_vec_r;

  logic [N_SRC-1:0] s_s, status_s, wdata_s, w1c_s, swset_s, pending_nxt_s;
  logic             en_we_s, mode_we_s, pol_we_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  function automatic logic [31:0] ext(input logic [N_SRC-1:0] v);
    ext = 32'd0;
    ext[N_SRC-1:0] = v;
  endfunction

  // Lowest index wins; result is index+1 so 0 can mean "none".
  function automatic logic [5:0] prio_enc(input logic [N_SRC-1:0] v);
    prio_enc = 6'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = 6'(i + 1);
    end
  endfunction

  assign s_s      = sync_r[SYNC_STAGES-1] ^ polarity_r;
  assign status_s = pending_r & enable_r;
  assign wdata_s  = bus.HWDATA[N_SRC-1:0];
  assign unused_s = ^{bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

  // Decode the data-phase write into per-register strobes.
  always_comb begin
    w1c_s     = {N_SRC{1'b0}};
    swset_s   = {N_SRC{1'b0}};
    en_we_s   = 1'b0;
    mode_we_s = 1'b0;
    pol_we_s  = 1'b0;
    case ({dp_valid_r & dp_write_r, dp_addr_r})
      4'b1_001: w1c_s     = wdata_s;
      4'b1_010: en_we_s   = 1'b1;
      4'b1_011: mode_we_s = 1'b1;
      4'b1_100: pol_we_s  = 1'b1;
      4'b1_101: swset_s   = wdata_s;
      default:  w1c_s     = {N_SRC{1'b0}};
    endcase
  end

  // Edge sources: set (edge or SWSET) beats W1C. Level sources track s.
  assign pending_nxt_s = (mode_r  & ((pending_r & ~w1c_s) | (s_s & ~prev_r) | swset_s))
                       | (~mode_r & s_s);

  // Read mux driven from the registered address phase.
  always_comb begin
    rdata_s = 32'd0;
    case ({dp_valid_r & ~dp_write_r, dp_addr_r})
      4'b1_000: rdata_s = ext(status_s);
      4'b1_001: rdata_s = ext(pending_r);
      4'b1_010: rdata_s = ext(enable_r);
      4'b1_011: rdata_s = ext(mode_r);
      4'b1_100: rdata_s = ext(polarity_r);
      4'b1_110: rdata_s = {(irq_vec_r != 6'd0), 25'd0, irq_vec_r};
      default:  rdata_s = 32'd0;
    endcase
  end

  // All state: synchronisers, config, pending, bus address phase, outputs.
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      sync_r     <= '0;
      prev_r     <= {N_SRC{1'b0}};
      pending_r  <= {N_SRC{1'b0}};
      enable_r   <= {N_SRC{1'b0}};
      mode_r     <= {N_SRC{1'b0}};
      polarity_r <= {N_SRC{1'b0}};
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 3'd0;
      irq_r      <= 1'b0;
      irq_vec_r  <= 6'd0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], IRQ_SRC};
      prev_r     <= s_s;
      pending_r  <= pending_nxt_s;
      if (en_we_s)   enable_r   <= wdata_s;
      if (mode_we_s) mode_r     <= wdata_s;
      if (pol_we_s)  polarity_r <= wdata_s;
      dp_valid_r <= bus.HSEL & bus.HTRANS[1];
      dp_write_r <= bus.HWRITE;
      dp_addr_r  <= bus.HADDR[4:2];
      irq_r      <= |status_s;
      irq_vec_r  <= prio_enc(status_s);
    end
  end

  assign bus.HRDATA = rdata_s;
  assign bus.HREADY = 1'b1;
  assign bus.HRESP  = 1'b0;
  assign irq        = irq_r;
  assign irq_vec    = irq_vec_r;

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Directed bench for mfp_ahb_intc: register table plus hand-timed sequences.
module tb_mfp_ahb_intc;

  localparam logic [4:0] A_STATUS = 5'h00, A_PEND = 5'h04, A_EN = 5'h08,
                         A_MODE = 5'h0C, A_POL = 5'h10, A_SWSET = 5'h14,
                         A_VEC = 5'h18, A_RSVD = 5'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic        irq;
  logic [5:0]  irq_vec;

  int n_vec = 0;
  int n_err = 0;

  mfp_ahb_intc_if bus_if ();

  mfp_ahb_intc #(.N_SRC(16), .SYNC_STAGES(2)) dut (
    .HCLK(clk), .SI_Reset(rst), .bus(bus_if),
    .IRQ_SRC(irq_src), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Address phase now (at a negedge); returns in the data phase, one negedge later.
  task automatic bus(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    bus_if.HSEL   = 1'b1;
    bus_if.HTRANS = 2'b10;
    bus_if.HWRITE = wr;
    bus_if.HADDR  = addr;
    @(negedge clk);
    bus_if.HSEL   = 1'b0;
    bus_if.HTRANS = 2'b00;
    bus_if.HWRITE = 1'b0;
    bus_if.HADDR  = 5'h00;
    bus_if.HWDATA = wd;
    rd = bus_if.HRDATA;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, addr, d, dummy);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, addr, 32'd0, r);
    check(name, r, exp);
    @(negedge clk);
  endtask

  task automatic chk_irq(input string name, input logic exp_irq, input logic [5:0] exp_vec);
    check({name, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    check({name, "_vec"}, {26'd0, irq_vec}, {26'd0, exp_vec});
  endtask

  initial begin
    logic [31:0] r;

    tbl[0]  = {1'b0, A_STATUS, 32'h0, 32'h0};
    tbl[1]  = {1'b0, A_PEND,   32'h0, 32'h0};
    tbl[2]  = {1'b0, A_EN,     32'h0, 32'h0};
    tbl[3]  = {1'b0, A_MODE,   32'h0, 32'h0};
    tbl[4]  = {1'b0, A_POL,    32'h0, 32'h0};
    tbl[5]  = {1'b0, A_SWSET,  32'h0, 32'h0};
    tbl[6]  = {1'b0, A_VEC,    32'h0, 32'h0};
    tbl[7]  = {1'b0, A_RSVD,   32'h0, 32'h0};
    tbl[8]  = {1'b1, A_EN,     32'hFFFF_FFFF, 32'h0};
    tbl[9]  = {1'b0, A_EN,     32'h0, 32'h0000_FFFF};
    tbl[10] = {1'b1, A_MODE,   32'h1234_5678, 32'h0};
    tbl[11] = {1'b0, A_MODE,   32'h0, 32'h0000_5678};
    tbl[12] = {1'b1, A_MODE,   32'h0000_FFFF, 32'h0};
    tbl[13] = {1'b1, A_POL,    32'h0000_ABCD, 32'h0};
    tbl[14] = {1'b0, A_POL,    32'h0, 32'h0000_ABCD};
    tbl[15] = {1'b0, A_PEND,   32'h0, 32'h0000_ABCD};
    tbl[16] = {1'b0, A_STATUS, 32'h0, 32'h0000_ABCD};
    tbl[17] = {1'b0, A_VEC,    32'h0, 32'h8000_0001};
    tbl[18] = {1'b1, A_SWSET,  32'h0000_0030, 32'h0};
    tbl[19] = {1'b0, A_SWSET,  32'h0, 32'h0};
    tbl[20] = {1'b0, A_PEND,   32'h0, 32'h0000_ABFD};
    tbl[21] = {1'b1, A_RSVD,   32'hFFFF_FFFF, 32'h0};
    tbl[22] = {1'b0, A_RSVD,   32'h0, 32'h0};
    tbl[23] = {1'b0, A_EN,     32'h0, 32'h0000_FFFF};
    tbl[24] = {1'b1, A_PEND,   32'h0000_FFFF, 32'h0};
    tbl[25] = {1'b0, A_PEND,   32'h0, 32'h0};
    tbl[26] = {1'b1, A_POL,    32'h0, 32'h0};
    tbl[27] = {1'b1, A_MODE,   32'h0, 32'h0};
    tbl[28] = {1'b1, A_EN,     32'h0, 32'h0};
    tbl[29] = {1'b0, A_STATUS, 32'h0, 32'h0};
    tbl[30] = {1'b0, A_VEC,    32'h0, 32'h0};

    rst = 1'b1;
    irq_src = 16'h0000;
    bus_if.HSEL = 1'b0; bus_if.HTRANS = 2'b00; bus_if.HWRITE = 1'b0;
    bus_if.HADDR = 5'h00; bus_if.HWDATA = 32'h0;
    repeat (3) @(negedge clk);
    chk_irq("reset", 1'b0, 6'd0);
    check("reset_hready", {31'd0, bus_if.HREADY}, 32'd1);
    check("reset_hresp",  {31'd0, bus_if.HRESP},  32'd0);
    check("reset_hrdata", bus_if.HRDATA, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      bus(tbl[i].wr, tbl[i].addr, tbl[i].data, r);
      if (!tbl[i].wr) check($sformatf("vec%0d", i), r, tbl[i].exp);
      @(negedge clk);
    end

    // Edge source 0: 2-cycle pulse, irq 3 cycles after first sample.
    wr(A_EN, 32'h0005);
    wr(A_MODE, 32'h0001);
    irq_src[0] = 1'b1;
    repeat (2) @(negedge clk);
    irq_src[0] = 1'b0;
    @(negedge clk);
    chk_irq("lat_e2", 1'b0, 6'd0);
    @(negedge clk);
    chk_irq("lat_e3", 1'b1, 6'd1);
    rd_chk("edge_pend", A_PEND, 32'h0001);
    bus(1'b1, A_PEND, 32'h0001, r);
    @(negedge clk);
    check("w1c_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk_irq("w1c_clr", 1'b0, 6'd0);

    // Level source 2 ignores W1C and follows the line.
    irq_src[2] = 1'b1;
    repeat (5) @(negedge clk);
    chk_irq("lvl_on", 1'b1, 6'd3);
    rd_chk("lvl_pend", A_PEND, 32'h0004);
    wr(A_PEND, 32'h0004);
    rd_chk("lvl_w1c", A_PEND, 32'h0004);
    irq_src[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("lvl_rel_e2", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk_irq("lvl_rel_e3", 1'b0, 6'd0);

    // Priority between sources 3 and 9.
    wr(A_MODE, 32'h0209);
    wr(A_EN, 32'hFFFF);
    wr(A_SWSET, 32'h0208);
    repeat (2) @(negedge clk);
    chk_irq("prio_3", 1'b1, 6'd4);
    rd_chk("prio_status", A_STATUS, 32'h0208);
    wr(A_PEND, 32'h0008);
    repeat (2) @(negedge clk);
    chk_irq("prio_9", 1'b1, 6'd10);
    rd_chk("prio_vecreg", A_VEC, 32'h8000_000A);
    wr(A_PEND, 32'hFFFF);

    // Edge on source 1 lands on the same edge as W1C of bit 1.
    wr(A_MODE, 32'h020B);
    irq_src[1] = 1'b1;
    @(negedge clk);
    bus(1'b1, A_PEND, 32'h0002, r);
    repeat (2) @(negedge clk);
    rd_chk("set_wins", A_PEND, 32'h0002);
    wr(A_PEND, 32'h0002);
    rd_chk("w1c_after", A_PEND, 32'h0000);
    irq_src[1] = 1'b0;

    // Active-low edge source 5: pending only on falling line edge.
    wr(A_MODE, 32'h022B);
    wr(A_POL, 32'h0020);
    repeat (2) @(negedge clk);
    wr(A_PEND, 32'h0020);
    rd_chk("pol_clean", A_PEND, 32'h0000);
    irq_src[5] = 1'b1;
    repeat (5) @(negedge clk);
    rd_chk("pol_rise", A_PEND, 32'h0000);
    irq_src[5] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("pol_fall", A_PEND, 32'h0020);
    wr(A_PEND, 32'h0020);
    repeat (3) @(negedge clk);
    rd_chk("pol_once", A_PEND, 32'h0000);
    wr(A_SWSET, 32'h0004);
    rd_chk("swset_lvl", A_PEND, 32'h0000);
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd_chk("rsvd_en", A_EN, 32'hFFFF);
    rd_chk("rsvd_mode", A_MODE, 32'h022B);
    rd_chk("rsvd_pol", A_POL, 32'h0020);

    // Back-to-back write then read, no idle between.
    bus(1'b1, A_EN, 32'h1234, r);
    bus(1'b0, A_EN, 32'h0, r);
    check("b2b_en", r, 32'h1234);
    @(negedge clk);

    // Reset during a write data phase discards the write.
    bus(1'b1, A_EN, 32'hAAAA, r);
    rst = 1'b1;
    @(negedge clk);
    chk_irq("midrst", 1'b0, 6'd0);
    check("midrst_hready", {31'd0, bus_if.HREADY}, 32'd1);
    check("midrst_hrdata", bus_if.HRDATA, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_chk("midrst_en", A_EN, 32'h0);
    rd_chk("midrst_pol", A_POL, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
